// File: rtl/hazard_pkg.sv
// Shared constants and types for the register-writeback hazard scoreboard.
// A countdown value is the number of cycles until a result can be forwarded.
package hazard_pkg;

    localparam int unsigned REG_AW       = 5;
    localparam int unsigned DEF_ALU_LAT  = 1;
    localparam int unsigned DEF_LOAD_LAT = 2;
    localparam int unsigned DEF_CW       = $clog2(DEF_LOAD_LAT + 1);

    typedef logic [DEF_CW-1:0] cnt_t;

    // EX consumers pick up data through forwarding one cycle after ID consumers.
    typedef enum logic {
        EX_CONSUMER = 1'b0,
        ID_CONSUMER = 1'b1
    } consumer_e;

    function automatic logic [DEF_CW-1:0] consumer_thr(input consumer_e cls);
        return (cls == ID_CONSUMER) ? DEF_CW'(0) : DEF_CW'(1);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a saturating down-counter that can be loaded or held.
// A load takes priority over the hold and the decrement on the same edge.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          hold,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard deciding load-use and
// branch-operand stalls, with an external freeze that overrides everything.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = hazard_pkg::REG_AW,
    parameter int unsigned ALU_LAT  = DEF_ALU_LAT,
    parameter int unsigned LOAD_LAT = DEF_LOAD_LAT,
    parameter int unsigned CW       = $clog2(LOAD_LAT + 1),
    parameter int unsigned PERF_W   = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [REG_AW-1:0] IF_IDRs,
    input  logic [REG_AW-1:0] IF_IDRt,
    input  logic              UsesRs,
    input  logic              UsesRt,
    input  logic              IdBranch,
    input  logic              IdValid,
    input  logic              IdRegWrite,
    input  logic              IdMemRead,
    input  logic [REG_AW-1:0] IdDst,
    input  logic              Freeze,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic              Stall,
    output logic [PERF_W-1:0] StallCycles
);

    logic [CW-1:0]     cnt [NUM_REGS];
    logic [CW-1:0]     thr;
    logic [CW-1:0]     new_val;
    consumer_e         cls;
    logic              hz_rs;
    logic              hz_rt;
    logic              hazard;
    logic              issue;
    logic              wr_en;
    logic [PERF_W-1:0] stall_cycles_q;

    assign cls = IdBranch ? ID_CONSUMER : EX_CONSUMER;

    always_comb begin
        thr = CW'(1);
        if (cls == ID_CONSUMER) begin
            thr = '0;
        end
    end

    assign hz_rs  = UsesRs && (IF_IDRs != '0) && (cnt[IF_IDRs] > thr);
    assign hz_rt  = UsesRt && (IF_IDRt != '0) && (cnt[IF_IDRt] > thr);
    assign hazard = IdValid && (hz_rs || hz_rt);
    assign issue  = IdValid && !hazard && !Freeze;
    assign wr_en  = issue && IdRegWrite;

    assign new_val = IdMemRead ? CW'(LOAD_LAT) : CW'(ALU_LAT);

    // r0 is hardwired zero, so it never gets a slot.
    assign cnt[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        sb_entry #(
            .CW (CW)
        ) u_entry (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .hold     (Freeze),
            .load     (wr_en && (IdDst == REG_AW'(i))),
            .load_val (new_val),
            .cnt      (cnt[i])
        );
    end

    always_comb begin
        PCWrite    = 1'b1;
        IF_IDWrite = 1'b1;
        Stall      = 1'b0;
        if (Freeze) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
        end else if (hazard) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            Stall      = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cycles_q <= '0;
        end else if (hazard && !Freeze) begin
            stall_cycles_q <= stall_cycles_q + PERF_W'(1);
        end
    end

    assign StallCycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

    localparam int unsigned LOAD_LAT = 2;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  IF_IDRs;
    logic [4:0]  IF_IDRt;
    logic        UsesRs;
    logic        UsesRt;
    logic        IdBranch;
    logic        IdValid;
    logic        IdRegWrite;
    logic        IdMemRead;
    logic [4:0]  IdDst;
    logic        Freeze;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        Stall;
    logic [31:0] StallCycles;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        br;
        logic        vld;
        logic        rw;
        logic        mr;
        logic [4:0]  dst;
        logic        frz;
        logic        exp_stall;
        logic        exp_hold;
        logic [31:0] exp_sc;
    } vec_t;

    vec_t tbl [23];

    hazard_scoreboard #(
        .NUM_REGS (32),
        .REG_AW   (5),
        .ALU_LAT  (1),
        .LOAD_LAT (LOAD_LAT),
        .PERF_W   (32)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .IF_IDRs     (IF_IDRs),
        .IF_IDRt     (IF_IDRt),
        .UsesRs      (UsesRs),
        .UsesRt      (UsesRt),
        .IdBranch    (IdBranch),
        .IdValid     (IdValid),
        .IdRegWrite  (IdRegWrite),
        .IdMemRead   (IdMemRead),
        .IdDst       (IdDst),
        .Freeze      (Freeze),
        .PCWrite     (PCWrite),
        .IF_IDWrite  (IF_IDWrite),
        .Stall       (Stall),
        .StallCycles (StallCycles)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input int rs, input int rt, input int urs, input int urt,
                                input int br, input int vld, input int rw, input int mr,
                                input int dst, input int frz, input int es, input int eh,
                                input int sc);
        vec_t v;
        v.rs = 5'(rs);   v.rt = 5'(rt);   v.urs = 1'(urs); v.urt = 1'(urt);
        v.br = 1'(br);   v.vld = 1'(vld); v.rw = 1'(rw);   v.mr = 1'(mr);
        v.dst = 5'(dst); v.frz = 1'(frz);
        v.exp_stall = 1'(es); v.exp_hold = 1'(eh); v.exp_sc = 32'(sc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic es, input logic eh,
                                 input logic [31:0] sc);
        chk({tag, ".Stall"}, 32'(Stall), 32'(es));
        chk({tag, ".PCWrite"}, 32'(PCWrite), 32'(!eh));
        chk({tag, ".IF_IDWrite"}, 32'(IF_IDWrite), 32'(!eh));
        chk({tag, ".StallCycles"}, StallCycles, sc);
        // Continuous stall runs are bounded by the load latency.
        if (Stall) begin
            run_len++;
            checks++;
            if (run_len > LOAD_LAT) begin
                failures++;
                $display("FAIL %s.stall_run: got %0d expected at most %0d", tag, run_len,
                         LOAD_LAT);
            end
        end else begin
            run_len = 0;
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge Clk);
        IF_IDRs    = v.rs;
        IF_IDRt    = v.rt;
        UsesRs     = v.urs;
        UsesRt     = v.urt;
        IdBranch   = v.br;
        IdValid    = v.vld;
        IdRegWrite = v.rw;
        IdMemRead  = v.mr;
        IdDst      = v.dst;
        Freeze     = v.frz;
        #1;
        check_outputs(tag, v.exp_stall, v.exp_hold, v.exp_sc);
    endtask

    initial begin
        //            rs rt urs urt br vld rw mr dst frz  stall hold sc
        tbl[0]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 5,  0,   0, 0, 0); // alu -> r5
        tbl[1]  = mk(5, 0, 1, 0, 0, 1, 1, 0, 6,  0,   0, 0, 0); // alu reads r5
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 8,  0,   0, 0, 0); // load r8
        tbl[3]  = mk(8, 9, 1, 1, 0, 1, 1, 0, 10, 0,   1, 1, 0); // add r8: stall
        tbl[4]  = mk(8, 9, 1, 1, 0, 1, 1, 0, 10, 0,   0, 0, 1); // add issues
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 8,  0,   0, 0, 1); // load r8
        tbl[6]  = mk(8, 9, 1, 1, 1, 1, 0, 0, 0,  0,   1, 1, 1); // beq r8: stall 1
        tbl[7]  = mk(8, 9, 1, 1, 1, 1, 0, 0, 0,  0,   1, 1, 2); // beq r8: stall 2
        tbl[8]  = mk(8, 9, 1, 1, 1, 1, 0, 0, 0,  0,   0, 0, 3); // beq issues
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 7,  0,   0, 0, 3); // alu -> r7
        tbl[10] = mk(7, 7, 1, 1, 1, 1, 0, 0, 0,  0,   1, 1, 3); // beq r7,r7: one stall
        tbl[11] = mk(7, 7, 1, 1, 1, 1, 0, 0, 0,  0,   0, 0, 4);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0,  0,   0, 0, 4); // load r0
        tbl[13] = mk(0, 0, 1, 1, 0, 1, 1, 0, 11, 0,   0, 0, 4); // read r0: no stall
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 1, 1, 3,  0,   0, 0, 4); // load r3
        tbl[15] = mk(3, 3, 1, 1, 1, 0, 1, 1, 12, 0,   0, 0, 4); // bubble reading r3
        tbl[16] = mk(3, 0, 1, 0, 1, 1, 0, 0, 0,  0,   1, 1, 4); // beq r3: cnt=1
        tbl[17] = mk(3, 0, 1, 0, 1, 1, 0, 0, 0,  0,   0, 0, 5);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 1, 1, 4,  0,   0, 0, 5); // load r4
        tbl[19] = mk(4, 2, 0, 1, 0, 1, 1, 0, 13, 0,   0, 0, 5); // Rs unused
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 1, 1, 9,  0,   0, 0, 5); // load r9
        tbl[21] = mk(1, 9, 1, 1, 0, 1, 1, 0, 14, 0,   1, 1, 5); // Rt hazard
        tbl[22] = mk(1, 9, 1, 1, 0, 1, 1, 0, 14, 0,   0, 0, 6);

        Rst_n = 1'b0;
        IF_IDRs = '0; IF_IDRt = '0; UsesRs = 1'b0; UsesRt = 1'b0; IdBranch = 1'b0;
        IdValid = 1'b0; IdRegWrite = 1'b0; IdMemRead = 1'b0; IdDst = '0; Freeze = 1'b0;
        #1;
        check_outputs("reset", 1'b0, 1'b0, 32'd0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Freeze with a load-use consumer waiting in ID.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6), "frz_idle");
        apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, 0, 6), "frz_load");
        for (int i = 0; i < 3; i++) begin
            apply(mk(8, 0, 1, 0, 0, 1, 1, 0, 15, 1, 0, 1, 6), $sformatf("frz_hold%0d", i));
        end
        apply(mk(8, 0, 1, 0, 0, 1, 1, 0, 15, 0, 1, 1, 6), "frz_stall");
        apply(mk(8, 0, 1, 0, 0, 1, 1, 0, 15, 0, 0, 0, 7), "frz_issue");

        // Reset in the middle of a branch stall on a fresh load.
        apply(mk(0, 0, 0, 0, 0, 1, 1, 1, 8, 0, 0, 0, 7), "rst_load");
        apply(mk(8, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 7), "rst_stall");
        Rst_n = 1'b0;
        #1;
        check_outputs("rst_async", 1'b0, 1'b0, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        apply(mk(8, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "rst_after");
        apply(mk(8, 8, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rst_after2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle ID-stage hazard detector.
- Tracks outstanding register writes in a per-register countdown scoreboard. Decides stalls for load-use and for branch/JR operands read in ID.
- Load latency, ALU latency and register-file size are configurable.
- Sits beside the ID stage. Drives PC write-enable, IF/ID write-enable and the ID/EX bubble, and honours an external pipeline freeze.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hardwired zero.
- REG_AW, 5, register index width; must equal clog2(NUM_REGS).
- ALU_LAT, 1, cycles from issue until an ALU result can be forwarded to an ID-stage consumer.
- LOAD_LAT, 2, same for loads; must satisfy LOAD_LAT >= ALU_LAT >= 1.
- CW, clog2(LOAD_LAT+1), countdown counter width (derived).
- PERF_W, 32, stall-cycle counter width.

Ports:
- Clk  in  1  pipeline clock.
- Rst_n  in  1  asynchronous active-low reset.
- IF_IDRs  in  REG_AW  source register Rs of the instruction in ID.
- IF_IDRt  in  REG_AW  source register Rt of the instruction in ID.
- UsesRs  in  1  ID instruction reads Rs.
- UsesRt  in  1  ID instruction reads Rt.
- IdBranch  in  1  ID instruction is a branch or JR (compares operands in ID).
- IdValid  in  1  ID holds a real instruction, not a bubble.
- IdRegWrite  in  1  ID instruction writes a register.
- IdMemRead  in  1  ID instruction is a load.
- IdDst  in  REG_AW  destination of the ID instruction.
- Freeze  in  1  downstream stall, e.g. a memory miss.
- PCWrite  out  1  PC enable.
- IF_IDWrite  out  1  IF/ID enable.
- Stall  out  1  insert a bubble into ID/EX.
- StallCycles  out  PERF_W  count of hazard-stall cycles.

Behaviour:
- Reset (async, Rst_n=0):
  - All counters cnt[0..NUM_REGS-1] = 0.
  - StallCycles = 0.
  - Combinational outputs settle to PCWrite=1, IF_IDWrite=1, Stall=0.
- Hazard condition (combinational, from registered cnt), per source s in {Rs,Rt}:
  - hz_s = Uses_s & (s != 0) & (cnt[s] > thr).
  - thr = 0 if IdBranch, else 1. Non-branch consumers receive data through EX forwarding one cycle later.
  - hazard = IdValid & (hz_Rs | hz_Rt).
- Output priority:
  - Freeze=1: PCWrite=0, IF_IDWrite=0, Stall=0. Pipeline holds and no bubble is inserted.
  - Else hazard=1: PCWrite=0, IF_IDWrite=0, Stall=1.
  - Else: PCWrite=1, IF_IDWrite=1, Stall=0.
- Issue: issue = IdValid & ~hazard & ~Freeze.
- Counter update, each rising Clk edge:
  - Freeze=1: all counters hold.
  - Otherwise each nonzero counter decrements by 1, saturating at 0.
  - Then, if issue & IdRegWrite & (IdDst != 0), cnt[IdDst] = IdMemRead ? LOAD_LAT : ALU_LAT. The new value overrides the decrement for that entry on the same edge.
  - cnt[0] is never written and always reads 0.
- StallCycles increments by 1 on every edge where hazard & ~Freeze. Wraps modulo 2^PERF_W with no saturation.
- Resulting latencies with default parameters:
  - ALU → ALU consumer: 0 stalls.
  - Load → ALU consumer: 1 stall.
  - ALU → branch: 1 stall.
  - Load → branch: 2 stalls.
- Maximum continuous hazard stall is LOAD_LAT cycles. A longer run is a design error and is covered by a bench assertion.
- Reset mid-stall clears all counters at once; the next cycle has no hazard.
- A ID instruction whose Rs==Rt is treated as one dependency: same stall count as a single source.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_AW and the default latency constants.
  - A typedef for the counter width.
  - An enum for consumer class (EX_CONSUMER, ID_CONSUMER) used to select thr.
- One natural sub-module, sb_entry: a single saturating countdown with load, hold and decrement. It is instantiated NUM_REGS-1 times in a generate loop.

Test Plan:
- Reset, then an ALU op writing r5, then an ALU op reading r5 → Stall stays 0 every cycle; StallCycles=0.
- Load to r8, then `add` reading r8 → exactly 1 cycle with PCWrite=0, IF_IDWrite=0, Stall=1; the add issues on the next cycle; StallCycles=1.
- Load to r8, then `beq` r8,r9 → 2 consecutive stall cycles; with an ALU producer instead → 1 stall cycle.
- Load to r0, then a consumer reading r0 → no stall; cnt[0] remains 0.
- Load to r8, then Freeze=1 for 3 cycles with the consumer in ID → Stall=0 and PCWrite=0 during Freeze; the 1-cycle hazard stall still occurs after Freeze drops; StallCycles=1.
- Load to r8, assert Rst_n=0 mid-stall → outputs return to PCWrite=1, Stall=0 immediately; after release, the consumer issues with no stall.
